// File: rtl/core_dispatcher.sv
// Ingress dispatcher: routes whole packets from one 64-bit stream to one of four cores,
// round-robin among free cores, with a per-core dispatched-packet counter.
module core_dispatcher #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CTRL_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic [CTRL_WIDTH-1:0]  in_ctrl,
    input  logic                   in_wr,
    output logic                   in_rdy,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_bop,
    output logic                   out_eop,
    output logic [3:0]             out_wr,
    input  logic [3:0]             core_free,
    input  logic [3:0]             core_rdy,
    output logic [1:0]             cur_core,
    output logic [4*CNT_WIDTH-1:0] pkt_cnt
);

    typedef enum logic {StIdle, StXfer} state_e;

    state_e                      state_q, state_d;
    logic [1:0]                  rr_ptr_q, rr_ptr_d;
    logic [1:0]                  cur_core_q, cur_core_d;
    logic                        first_word_q, first_word_d;
    logic [DATA_WIDTH-1:0]       out_data_q, out_data_d;
    logic                        out_bop_q, out_bop_d;
    logic                        out_eop_q, out_eop_d;
    logic [3:0]                  out_wr_q, out_wr_d;
    logic [3:0][CNT_WIDTH-1:0]   cnt_q, cnt_d;

    logic       grant_valid;
    logic [1:0] grant_idx;
    logic       accept;
    logic       eop_word;

    // Walk offsets from farthest to nearest so the nearest free core after rr_ptr wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            if (core_free[rr_ptr_q + 2'(k)]) begin
                grant_valid = 1'b1;
                grant_idx   = rr_ptr_q + 2'(k);
            end
        end
    end

    assign in_rdy   = (state_q == StXfer) && core_rdy[cur_core_q];
    assign accept   = in_wr && in_rdy;
    assign eop_word = (in_ctrl != '0) && (in_ctrl != {CTRL_WIDTH{1'b1}});

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        cur_core_d   = cur_core_q;
        first_word_d = first_word_q;
        out_data_d   = out_data_q;
        out_bop_d    = out_bop_q;
        out_eop_d    = out_eop_q;
        out_wr_d     = 4'b0000;
        cnt_d        = cnt_q;
        case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    cur_core_d   = grant_idx;
                    first_word_d = 1'b1;
                    state_d      = StXfer;
                end
            end
            StXfer: begin
                if (accept) begin
                    out_data_d   = in_data;
                    out_bop_d    = first_word_q;
                    out_eop_d    = eop_word;
                    out_wr_d     = 4'b0001 << cur_core_q;
                    first_word_d = 1'b0;
                    if (eop_word) begin
                        state_d           = StIdle;
                        rr_ptr_d          = cur_core_q;
                        cnt_d[cur_core_q] = cnt_q[cur_core_q] + CNT_WIDTH'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            rr_ptr_q     <= 2'd3;
            cur_core_q   <= 2'd0;
            first_word_q <= 1'b1;
            out_data_q   <= '0;
            out_bop_q    <= 1'b0;
            out_eop_q    <= 1'b0;
            out_wr_q     <= 4'b0000;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            cur_core_q   <= cur_core_d;
            first_word_q <= first_word_d;
            out_data_q   <= out_data_d;
            out_bop_q    <= out_bop_d;
            out_eop_q    <= out_eop_d;
            out_wr_q     <= out_wr_d;
            cnt_q        <= cnt_d;
        end
    end

    assign out_data = out_data_q;
    assign out_bop  = out_bop_q;
    assign out_eop  = out_eop_q;
    assign out_wr   = out_wr_q;
    assign cur_core = cur_core_q;
    assign pkt_cnt  = cnt_q;

endmodule

// File: tb/tb_core_dispatcher.sv
// Directed bench for core_dispatcher: expected output words are queued as stimulus is
// driven and popped as the DUT emits them on out_wr.
module tb_core_dispatcher;

    localparam int unsigned DW  = 64;
    localparam int unsigned CTW = 8;
    localparam int unsigned CW  = 8;

    logic            clk;
    logic            reset;
    logic [DW-1:0]   in_data;
    logic [CTW-1:0]  in_ctrl;
    logic            in_wr;
    logic            in_rdy;
    logic [DW-1:0]   out_data;
    logic            out_bop;
    logic            out_eop;
    logic [3:0]      out_wr;
    logic [3:0]      core_free;
    logic [3:0]      core_rdy;
    logic [1:0]      cur_core;
    logic [4*CW-1:0] pkt_cnt;

    core_dispatcher #(
        .DATA_WIDTH (DW),
        .CTRL_WIDTH (CTW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .in_wr     (in_wr),
        .in_rdy    (in_rdy),
        .out_data  (out_data),
        .out_bop   (out_bop),
        .out_eop   (out_eop),
        .out_wr    (out_wr),
        .core_free (core_free),
        .core_rdy  (core_rdy),
        .cur_core  (cur_core),
        .pkt_cnt   (pkt_cnt)
    );

    typedef struct {
        logic [1:0]    core;
        logic [DW-1:0] data;
        logic          bop;
        logic          eop;
    } exp_t;

    exp_t          sb[$];
    int            n_cmp = 0;
    int            n_fail = 0;
    logic [CW-1:0] exp_cnt [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed time limit reached, required summary before limit");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then compare any emitted word against the scoreboard head.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (out_wr != 4'b0000) begin
            if (sb.size() == 0) begin
                check("unexpected_word", 64'(out_wr), 64'd0);
            end else begin
                e = sb.pop_front();
                check("out_wr", 64'(out_wr), 64'(4'b0001 << e.core));
                check("out_data", out_data, e.data);
                check("out_bop", 64'(out_bop), 64'(e.bop));
                check("out_eop", 64'(out_eop), 64'(e.eop));
            end
        end
    endtask

    task automatic drive_word(input logic [1:0] core, input int idx, input int nwords);
        exp_t e;
        in_wr   = 1'b1;
        in_data = {$urandom, $urandom};
        in_ctrl = (idx == 0) ? 8'hFF : (idx == nwords - 1) ? 8'h01 : 8'h00;
        e.core  = core;
        e.data  = in_data;
        e.bop   = (idx == 0);
        e.eop   = (idx == nwords - 1);
        sb.push_back(e);
        if (idx == nwords - 1) exp_cnt[core] = exp_cnt[core] + 1'b1;
    endtask

    task automatic check_cnts(input string tag);
        for (int i = 0; i < 4; i++) check(tag, 64'(pkt_cnt[i*CW +: CW]), 64'(exp_cnt[i]));
    endtask

    // Starts in an IDLE cycle; returns right after the edge that accepts the eop word.
    task automatic send_pkt(input logic [1:0] core, input int nwords, input bit toggle);
        int sent = 0;
        int cyc = 0;
        bit granted = 1'b0;
        while (sent < nwords && cyc < 200) begin
            if (toggle && granted) core_rdy[core] = cyc[1];
            #1;
            if (granted) check("in_rdy_track", 64'(in_rdy), 64'(core_rdy[core]));
            if (in_rdy) begin
                if (!granted) begin
                    granted = 1'b1;
                    check("cur_core", 64'(cur_core), 64'(core));
                end
                drive_word(core, sent, nwords);
                sent++;
            end else begin
                in_wr = 1'b0;
            end
            step();
            cyc++;
        end
        in_wr    = 1'b0;
        in_ctrl  = 8'h00;
        core_rdy = 4'hF;
        if (sent < nwords) check("pkt_timeout", 64'(sent), 64'(nwords));
        check("sb_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int sent;
        reset     = 1'b1;
        in_data   = '0;
        in_ctrl   = '0;
        in_wr     = 1'b0;
        core_free = 4'h0;
        core_rdy  = 4'hF;
        for (int i = 0; i < 4; i++) exp_cnt[i] = '0;

        // Reset state
        repeat (3) step();
        check("rst_in_rdy", 64'(in_rdy), 64'd0);
        check("rst_out_wr", 64'(out_wr), 64'd0);
        check("rst_out_bop", 64'(out_bop), 64'd0);
        check("rst_out_eop", 64'(out_eop), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_cur_core", 64'(cur_core), 64'd0);
        check_cnts("rst_cnt");
        reset = 1'b0;

        // Round-robin over all-free cores
        core_free = 4'hF;
        send_pkt(2'd0, 4, 1'b0);
        send_pkt(2'd1, 4, 1'b0);
        send_pkt(2'd2, 4, 1'b0);
        check_cnts("rr_cnt");

        // Sparse free mask
        core_free = 4'b1010;
        send_pkt(2'd3, 4, 1'b0);
        send_pkt(2'd1, 4, 1'b0);

        // Backpressure toggling during an 8-word packet
        core_free = 4'hF;
        send_pkt(2'd2, 8, 1'b1);
        check_cnts("bp_cnt");

        // Reset on word 3 of a 6-word packet bound for core 3
        sent = 0;
        for (int c = 0; c < 20 && sent < 2; c++) begin
            #1;
            if (in_rdy) begin
                drive_word(2'd3, sent, 6);
                sent++;
            end else begin
                in_wr = 1'b0;
            end
            step();
        end
        #1;
        check("pre_rst_in_rdy", 64'(in_rdy), 64'd1);
        in_wr   = 1'b1;
        in_ctrl = 8'h00;
        reset   = 1'b1;
        step();
        for (int i = 0; i < 4; i++) exp_cnt[i] = '0;
        check("midrst_out_wr", 64'(out_wr), 64'd0);
        check("midrst_in_rdy", 64'(in_rdy), 64'd0);
        check("midrst_out_bop", 64'(out_bop), 64'd0);
        check("midrst_out_data", out_data, 64'd0);
        check("midrst_sb_empty", 64'(sb.size()), 64'd0);
        check_cnts("midrst_cnt");
        reset = 1'b0;
        in_wr = 1'b0;
        send_pkt(2'd0, 3, 1'b0);

        // Counter wrap on core 0 only
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) exp_cnt[i] = '0;
        core_free = 4'b0001;
        for (int p = 0; p < 255; p++) send_pkt(2'd0, 2, 1'b0);
        check_cnts("cnt_255");
        send_pkt(2'd0, 2, 1'b0);
        check_cnts("cnt_wrap");

        // No free core: stall, then release core 2
        core_free = 4'h0;
        step();
        for (int c = 0; c < 20; c++) begin
            check("stall_in_rdy", 64'(in_rdy), 64'd0);
            check("stall_out_wr", 64'(out_wr), 64'd0);
            step();
        end
        core_free = 4'b0100;
        #1;
        check("release_in_rdy_lo", 64'(in_rdy), 64'd0);
        step();
        check("release_in_rdy_hi", 64'(in_rdy), 64'd1);
        send_pkt(2'd2, 4, 1'b0);
        core_free = 4'h0;
        step();
        check_cnts("final_cnt");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
